// File: rtl/videocard_seq_pkg.sv
// Shared types and defaults for the videocard launch sequencer, core array and control block.
package videocard_seq_pkg;

   localparam int unsigned DefCores = 4;
   localparam int unsigned DefPassW = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLaunch = 3'd1,
      StWait   = 3'd2,
      StNext   = 3'd3,
      StFinish = 3'd4
   } seq_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for a slow level from another clock domain, plus a rising-edge pulse.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/videocard_launch_sequencer.sv
// Multi-pass launch sequencer for the videocard cores; start level in, finish level out.
// Optional WAIT-state watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module videocard_launch_sequencer
   import videocard_seq_pkg::*;
#(
   parameter int unsigned CORES     = DefCores,
   parameter int unsigned PASS_W    = DefPassW,
   parameter int unsigned DONE_HOLD = 4
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT   = 1024
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_req,
   input  logic [PASS_W-1:0] passes,
   output logic [CORES-1:0]  core_start,
   input  logic [CORES-1:0]  core_done,
   output logic              busy,
   output logic              finish,
   output logic [PASS_W-1:0] pass_count,
   output logic              error
);

   localparam int unsigned HoldW = $clog2(DONE_HOLD + 1);

   seq_state_e        state_q, state_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   logic [PASS_W-1:0] pass_count_q, pass_count_d;
   logic [CORES-1:0]  mask_q, mask_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              start_evt;

   sync_edge_detect u_start_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (start_req),
      .rise_o  (start_evt)
   );

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned WaitW = $clog2(TIMEOUT);
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             error_q, error_d;
`endif

   always_comb begin
      state_d      = state_q;
      passes_d     = passes_q;
      pass_count_d = pass_count_q;
      mask_d       = mask_q;
      hold_d       = hold_q;
      core_start   = '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_d   = wait_cnt_q;
      error_d      = error_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_evt) begin
               passes_d     = (passes == '0) ? PASS_W'(1) : passes;
               pass_count_d = '0;
               mask_d       = '0;
`ifdef SEQ_TIMEOUT_EN
               error_d      = 1'b0;
`endif
               state_d      = StLaunch;
            end
         end
         StLaunch: begin
            core_start = '1;
            // Clear and capture in one step so a done pulse in the launch cycle is kept.
            mask_d     = core_done;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d    = StWait;
         end
         StWait: begin
            mask_d = mask_q | core_done;
            if (&mask_d) begin
               state_d = StNext;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               hold_d  = HoldW'(DONE_HOLD - 1);
               state_d = StFinish;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         StNext: begin
            pass_count_d = pass_count_q + 1'b1;
            if (pass_count_d == passes_q) begin
               hold_d  = HoldW'(DONE_HOLD - 1);
               state_d = StFinish;
            end else begin
               state_d = StLaunch;
            end
         end
         StFinish: begin
            if (hold_q == '0) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         passes_q     <= '0;
         pass_count_q <= '0;
         mask_q       <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         passes_q     <= passes_d;
         pass_count_q <= pass_count_d;
         mask_q       <= mask_d;
         hold_q       <= hold_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         error_q    <= error_d;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign busy       = (state_q != StIdle);
   assign finish     = (state_q == StFinish);
   assign pass_count = pass_count_q;

endmodule

// File: tb/tb_videocard_launch_sequencer.sv
// Directed bench for videocard_launch_sequencer: launch table plus restart, reset and timeout cases.
module tb_videocard_launch_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start_req;
   logic [7:0] passes;
   logic [3:0] core_start;
   logic [3:0] core_done = '0;
   logic       busy;
   logic       finish;
   logic [7:0] pass_count;
   logic       error;

   videocard_launch_sequencer #(
      .CORES     (4),
      .PASS_W    (8),
      .DONE_HOLD (4)
`ifdef SEQ_TIMEOUT_EN
      ,
      .TIMEOUT   (16)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_req  (start_req),
      .passes     (passes),
      .core_start (core_start),
      .core_done  (core_done),
      .busy       (busy),
      .finish     (finish),
      .pass_count (pass_count),
      .error      (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Core model and launch statistics
   int   dly [4];
   int   cnt [4];
   int   starts, fin_cycles, fin_rises, first_start, first_fin, last_done, viol;
   logic fin_prev = 1'b0;

   always @(negedge clk) begin
      logic [3:0] dv;
      dv = '0;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt[i] = -1;
         fin_prev = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0) begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] == 0) begin
                  dv[i] = 1'b1;
                  if (fin_rises == 0) last_done = cyc;
               end
            end
         end
         if (core_start == 4'hF) begin
            if (starts > 0)
               for (int i = 0; i < 4; i++) if (cnt[i] != 0) viol++;
            if (starts == 0) first_start = cyc;
            starts++;
            for (int i = 0; i < 4; i++) cnt[i] = dly[i];
         end
         if (finish) begin
            if (!fin_prev) begin
               fin_rises++;
               if (fin_rises == 1) first_fin = cyc;
            end
            fin_cycles++;
         end
         fin_prev = finish;
      end
      core_done = dv;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      starts = 0; fin_cycles = 0; fin_rises = 0; viol = 0;
      first_start = -1; first_fin = -1; last_done = -1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(output int t);
      tick();
      t = cyc;
      start_req = 1'b1;
      repeat (6) tick();
      start_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(fin_rises > 0 && busy == 1'b0) && n < 2000) begin
         tick();
         n++;
      end
      check({name, "_done_in_time"}, int'(n < 2000), 1);
   endtask

   typedef struct {
      int passes;
      int d0, d1, d2, d3;
      int exp_starts;
      int exp_pc;
   } vec_t;

   vec_t vecs [5];
   int   t0, t1;

   initial begin
      vecs[0] = '{passes: 1, d0: 5, d1: 5, d2: 5, d3: 5, exp_starts: 1, exp_pc: 1};
      vecs[1] = '{passes: 3, d0: 1, d1: 4, d2: 6, d3: 9, exp_starts: 3, exp_pc: 3};
      vecs[2] = '{passes: 0, d0: 2, d1: 2, d2: 2, d3: 2, exp_starts: 1, exp_pc: 1};
      vecs[3] = '{passes: 2, d0: 7, d1: 1, d2: 3, d3: 2, exp_starts: 2, exp_pc: 2};
      vecs[4] = '{passes: 5, d0: 1, d1: 1, d2: 1, d3: 1, exp_starts: 5, exp_pc: 5};

      rst_n = 1'b0;
      start_req = 1'b0;
      passes = '0;
      clear_stats();
      #12;
      check("reset_core_start", int'(core_start), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_finish", int'(finish), 0);
      check("reset_pass_count", int'(pass_count), 0);
      check("reset_error", int'(error), 0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      foreach (vecs[k]) begin
         clear_stats();
         dly[0] = vecs[k].d0; dly[1] = vecs[k].d1; dly[2] = vecs[k].d2; dly[3] = vecs[k].d3;
         passes = 8'(vecs[k].passes);
         pulse_start(t0);
         wait_idle($sformatf("vec%0d", k));
         check($sformatf("vec%0d_starts", k), starts, vecs[k].exp_starts);
         check($sformatf("vec%0d_pass_count", k), int'(pass_count), vecs[k].exp_pc);
         check($sformatf("vec%0d_finish_cycles", k), fin_cycles, 4);
         check($sformatf("vec%0d_finish_rises", k), fin_rises, 1);
         check($sformatf("vec%0d_start_latency", k), first_start - t0, 3);
         check($sformatf("vec%0d_done_to_finish", k), first_fin - last_done, 2);
         check($sformatf("vec%0d_launch_order", k), viol, 0);
         check($sformatf("vec%0d_error", k), int'(error), 0);
         repeat (3) tick();
      end

      // Second start rise while waiting on the cores is dropped.
      clear_stats();
      dly[0] = 20; dly[1] = 20; dly[2] = 20; dly[3] = 20;
      passes = 8'd1;
      pulse_start(t0);
      repeat (4) tick();
      check("restart_busy_in_wait", int'(busy), 1);
      pulse_start(t1);
      wait_idle("restart");
      repeat (10) tick();
      check("restart_starts", starts, 1);
      check("restart_finish_rises", fin_rises, 1);
      check("restart_busy_after", int'(busy), 0);

      // Asynchronous reset during the second pass, then a clean relaunch.
      clear_stats();
      dly[0] = 10; dly[1] = 10; dly[2] = 10; dly[3] = 10;
      passes = 8'd3;
      pulse_start(t0);
      t1 = 0;
      while (starts < 2 && t1 < 200) begin
         tick();
         t1++;
      end
      check("rst_second_pass_seen", starts, 2);
      repeat (3) tick();
      check("rst_busy_before", int'(busy), 1);
      check("rst_pass_count_before", int'(pass_count), 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_pass_count", int'(pass_count), 0);
      check("rst_async_core_start", int'(core_start), 0);
      check("rst_async_finish", int'(finish), 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      clear_stats();
      dly[0] = 3; dly[1] = 3; dly[2] = 3; dly[3] = 3;
      passes = 8'd2;
      pulse_start(t0);
      wait_idle("relaunch");
      check("relaunch_starts", starts, 2);
      check("relaunch_pass_count", int'(pass_count), 2);
      check("relaunch_finish_cycles", fin_cycles, 4);

`ifdef SEQ_TIMEOUT_EN
      // Core 2 never completes; the watchdog forces a finish with error set.
      clear_stats();
      dly[0] = 2; dly[1] = 2; dly[2] = -1; dly[3] = 2;
      passes = 8'd1;
      pulse_start(t0);
      wait_idle("timeout");
      check("timeout_error", int'(error), 1);
      check("timeout_finish_delay", first_fin - first_start, 17);
      check("timeout_finish_cycles", fin_cycles, 4);
      check("timeout_pass_count", int'(pass_count), 0);
      clear_stats();
      dly[0] = 2; dly[1] = 2; dly[2] = 2; dly[3] = 2;
      pulse_start(t0);
      check("timeout_error_cleared", int'(error), 0);
      wait_idle("after_timeout");
      check("after_timeout_pass_count", int'(pass_count), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
